// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: bus layout, CP0 address map,
// exception encodings and the ex_code -> Cause.ExcCode translation.
package wb_stage_pkg;

  localparam int          MS_TO_WS_BUS_WD = 117;
  localparam logic [31:0] EX_ENTRY_DEF    = 32'hBFC0_0380;

  // CP0 addresses as {rd, sel}
  localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

  typedef enum logic [2:0] {
    EX_NONE = 3'd0, EX_INT = 3'd1, EX_ADEL = 3'd2, EX_ADES = 3'd3,
    EX_SYS  = 3'd4, EX_BP  = 3'd5, EX_RI   = 3'd6, EX_OV   = 3'd7
  } ex_code_e;

  // Field order matches the mem_stage packing, MSB first (117 bits).
  typedef struct packed {
    logic [31:0] badvaddr;
    logic [7:0]  cp0_addr;
    logic        mfc0;
    logic        mtc0;
    ex_code_e    ex_code;
    logic        eret;
    logic        bd;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_to_ws_bus_t;

  function automatic logic [4:0] exc_code(input ex_code_e c);
    case (c)
      EX_INT:  return 5'h00;
      EX_ADEL: return 5'h04;
      EX_ADES: return 5'h05;
      EX_SYS:  return 5'h08;
      EX_BP:   return 5'h09;
      EX_RI:   return 5'h0a;
      EX_OV:   return 5'h0c;
      default: return 5'h00;
    endcase
  endfunction

endpackage

// File: rtl/wb_stage_cp0_regfile.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Ports: ex_i/eret_i commit events, mtc0_i write strobe (already qualified),
// addr_i {rd,sel} shared by read and write, wdata_i MTC0 data, exception
// info (ex_code_i, bd_i, pc_i, badvaddr_i), hw_int_i level interrupts.
// Outputs: rdata_o combinational MFC0 data, epc_o current EPC, int_req_o.
module cp0_regfile
  import wb_stage_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_i,
  input  logic        eret_i,
  input  logic        mtc0_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  ex_code_e    ex_code_i,
  input  logic        bd_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] badvaddr_i,
  input  logic [5:0]  hw_int_i,
  output logic [31:0] rdata_o,
  output logic [31:0] epc_o,
  output logic        int_req_o
);

  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic [31:0] epc_q, epc_d, badv_q, badv_d;
  logic [7:0]  im_q, im_d, ip_q, ip_d;
  logic        exl_q, exl_d, ie_q, ie_d;
  logic        bd_q, bd_d, ti_q, ti_d, tick_q, tick_d;
  logic [4:0]  exc_q, exc_d;
  logic        wr_compare;
  logic [31:0] status, cause;

  // BEV is hard-wired to 1; only IM/EXL/IE are stored.
  assign status = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause  = {bd_q, ti_q, 14'b0, ip_q, 1'b0, exc_q, 2'b0};

  always_comb begin
    tick_d     = ~tick_q;
    count_d    = count_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    badv_d     = badv_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_d      = exc_q;
    ip_d       = ip_q;
    ti_d       = ti_q;
    wr_compare = 1'b0;
    if (COUNT_DIV == 1 || tick_q) count_d = count_q + 32'd1;
    if (ex_i) begin
      exc_d = exc_code(ex_code_i);
      // Nested exceptions keep the original EPC/BD.
      if (!exl_q) begin
        epc_d = bd_i ? pc_i - 32'd4 : pc_i;
        bd_d  = bd_i;
      end
      exl_d = 1'b1;
      if (ex_code_i == EX_ADEL || ex_code_i == EX_ADES) badv_d = badvaddr_i;
    end else if (eret_i) begin
      exl_d = 1'b0;
    end else if (mtc0_i) begin
      case (addr_i)
        CP0_COUNT:   count_d = wdata_i;
        CP0_COMPARE: begin compare_d = wdata_i; wr_compare = 1'b1; end
        CP0_STATUS:  begin im_d = wdata_i[15:8]; exl_d = wdata_i[1]; ie_d = wdata_i[0]; end
        CP0_CAUSE:   ip_d[1:0] = wdata_i[9:8];
        CP0_EPC:     epc_d = wdata_i;
        default: ;
      endcase
    end
    // Timer match uses post-update values; a Compare write clears and wins.
    if (count_d == compare_d) ti_d = 1'b1;
    if (wr_compare)           ti_d = 1'b0;
    ip_d[7:2] = {hw_int_i[5] | ti_d, hw_int_i[4:0]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_q    <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      epc_q     <= '0;
      badv_q    <= '0;
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      exc_q     <= '0;
      ip_q      <= '0;
      ti_q      <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      epc_q     <= epc_d;
      badv_q    <= badv_d;
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      exc_q     <= exc_d;
      ip_q      <= ip_d;
      ti_q      <= ti_d;
    end
  end

  always_comb begin
    case (addr_i)
      CP0_BADVADDR: rdata_o = badv_q;
      CP0_COUNT:    rdata_o = count_q;
      CP0_COMPARE:  rdata_o = compare_q;
      CP0_STATUS:   rdata_o = status;
      CP0_CAUSE:    rdata_o = cause;
      CP0_EPC:      rdata_o = epc_q;
      default:      rdata_o = '0;
    endcase
  end

  assign epc_o     = epc_q;
  assign int_req_o = ie_q & ~exl_q & |(ip_q & im_q);

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: GPR write port and forwarding, exception/ERET commit
// with flush outputs (WS_EX, ERET, ex_pc), CP0 access via cp0_regfile,
// and the debug trace port. Always accepts (ws_allowin=1).
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY  = EX_ENTRY_DEF,
  parameter int          COUNT_DIV = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ws_allowin,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [4:0]                 WB_dest,
  output logic [31:0]                WB_dest_data,
  output logic                       WS_EX,
  output logic                       ERET,
  output logic [31:0]                ex_pc,
  input  logic [5:0]                 hw_int,
  output logic                       int_req,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  logic          ws_valid_q;
  ms_to_ws_bus_t bus_q;
  logic [31:0]   cp0_rdata, cp0_epc;
  logic          mtc0_we;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      // The instruction behind a committing exception/ERET is flushed with it.
      ws_valid_q <= (WS_EX | ERET) ? 1'b0 : ms_to_ws_valid;
      if (ms_to_ws_valid) bus_q <= ms_to_ws_bus_t'(ms_to_ws_bus);
    end
  end

  assign ws_allowin = 1'b1;
  assign WS_EX      = ws_valid_q && (bus_q.ex_code != EX_NONE);
  assign ERET       = ws_valid_q && bus_q.eret && (bus_q.ex_code == EX_NONE);
  assign ex_pc      = WS_EX ? EX_ENTRY : ERET ? cp0_epc : 32'h0;
  assign mtc0_we    = ws_valid_q & bus_q.mtc0 & ~WS_EX;

  assign rf_we        = ws_valid_q & bus_q.gr_we & ~WS_EX;
  assign rf_waddr     = bus_q.dest;
  assign rf_wdata     = bus_q.mfc0 ? cp0_rdata : bus_q.result;
  assign WB_dest      = bus_q.dest & {5{ws_valid_q}};
  assign WB_dest_data = rf_wdata & {32{ws_valid_q}};

  assign debug_wb_pc       = bus_q.pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  cp0_regfile #(.COUNT_DIV(COUNT_DIV)) u_cp0 (
    .clk       (clk),
    .resetn    (resetn),
    .ex_i      (WS_EX),
    .eret_i    (ERET),
    .mtc0_i    (mtc0_we),
    .addr_i    (bus_q.cp0_addr),
    .wdata_i   (bus_q.result),
    .ex_code_i (bus_q.ex_code),
    .bd_i      (bus_q.bd),
    .pc_i      (bus_q.pc),
    .badvaddr_i(bus_q.badvaddr),
    .hw_int_i  (hw_int),
    .rdata_o   (cp0_rdata),
    .epc_o     (cp0_epc),
    .int_req_o (int_req)
  );

endmodule
